// File: rtl/uart_tx_sched.sv
// uart_tx_sched: TX ring buffer owner and uart_tx arbiter.
// Handles the loader handshake byte and the program OUT ring. The ring lives
// in an external synchronous-read BRAM. count is authoritative for full/empty;
// the pointers just wrap.
module uart_tx_sched #(
  parameter int         ADDR_W  = 11,
  parameter int         RD_LAT  = 2,
  parameter logic [7:0] HS_BYTE = 8'hAA
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [2:0]        mode,
  input  logic              hs_req,
  output logic              hs_done,
  input  logic              push_valid,
  input  logic [7:0]        push_data,
  output logic              push_ready,
  output logic              buf_we,
  output logic [ADDR_W-1:0] buf_waddr,
  output logic [7:0]        buf_wdata,
  output logic [ADDR_W-1:0] buf_raddr,
  input  logic [7:0]        buf_rdata,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0] FULL   = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [2:0]      LAT_M1 = 3'(RD_LAT - 1);
  localparam logic [2:0]      MODE_LOAD = 3'd1;

  typedef enum logic [2:0] {IDLE, HS_START, RD_WAIT, START, GUARD, TX_WAIT} state_t;

  state_t            state;
  logic [ADDR_W-1:0] wptr, rptr;
  logic [2:0]        lat_cnt;
  logic              hs_cur;   // byte in flight is the handshake
  logic              hs_go, rd_go;

  assign push_ready = (count != FULL);
  assign buf_we     = push_valid & push_ready;
  assign buf_waddr  = wptr;
  assign buf_wdata  = push_data;
  assign buf_raddr  = rptr;

  // Handshake wins over the ring, but only when the FSM is idle.
  assign hs_go = (state == IDLE) & hs_req & ~hs_done & ~tx_busy;
  assign rd_go = (state == IDLE) & ~hs_go & (mode != MODE_LOAD) &
                 (count != '0) & ~tx_busy;

  // Ring pointers and occupancy; a push and a read in one cycle cancel on count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (buf_we) wptr <= wptr + 1'b1;
      if (rd_go)  rptr <= rptr + 1'b1;
      case ({buf_we, rd_go})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Serializer sequencing: read latency, start pulse, busy-assert guard, busy wait.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      tx_start <= 1'b0;
      tx_data  <= '0;
      hs_done  <= 1'b0;
      hs_cur   <= 1'b0;
      lat_cnt  <= '0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (hs_go) begin
            state    <= HS_START;
            tx_data  <= HS_BYTE;
            tx_start <= 1'b1;
            hs_cur   <= 1'b1;
          end else if (rd_go) begin
            state   <= RD_WAIT;
            lat_cnt <= LAT_M1;
            hs_cur  <= 1'b0;
          end
        end
        RD_WAIT: begin
          if (lat_cnt == '0) begin
            tx_data  <= buf_rdata;
            tx_start <= 1'b1;
            state    <= START;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        HS_START, START: state <= GUARD;
        // uart_tx may take a cycle to raise busy; do not trust it here.
        GUARD: state <= TX_WAIT;
        TX_WAIT: begin
          if (!tx_busy) begin
            state <= IDLE;
            if (hs_cur) hs_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: BRAM and uart_tx busy models, scoreboard of
// expected tx bytes checked by a monitor on every tx_start pulse.
module tb_uart_tx_sched;
  localparam int AW    = 3;
  localparam int RL    = 2;
  localparam int FRAME = 20;

  logic          clk = 1'b0, rstn = 1'b0;
  logic [2:0]    mode = 3'd0;
  logic          hs_req = 1'b0, hs_done;
  logic          push_valid = 1'b0, push_ready;
  logic [7:0]    push_data = 8'h00;
  logic          buf_we;
  logic [AW-1:0] buf_waddr, buf_raddr;
  logic [7:0]    buf_wdata, buf_rdata, tx_data;
  logic          tx_start, tx_busy;
  logic [AW:0]   count;

  uart_tx_sched #(.ADDR_W(AW), .RD_LAT(RL), .HS_BYTE(8'hAA)) dut (
    .clk(clk), .rstn(rstn), .mode(mode), .hs_req(hs_req), .hs_done(hs_done),
    .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
    .buf_we(buf_we), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata),
    .buf_raddr(buf_raddr), .buf_rdata(buf_rdata), .tx_data(tx_data),
    .tx_start(tx_start), .tx_busy(tx_busy), .count(count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // BRAM: synchronous read with RL cycles latency
  logic [7:0] mem [0:(1<<AW)-1];
  logic [7:0] pipe [0:RL-1];
  always @(posedge clk) begin
    if (buf_we) mem[buf_waddr] <= buf_wdata;
    pipe[0] <= mem[buf_raddr];
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end
  assign buf_rdata = pipe[RL-1];

  // uart_tx busy: FRAME cycles per start, plus a forced-busy override
  int   frame_cnt;
  logic busy_force = 1'b0;
  always @(posedge clk or negedge rstn) begin
    if (!rstn)              frame_cnt <= 0;
    else if (tx_start)      frame_cnt <= FRAME;
    else if (frame_cnt != 0) frame_cnt <= frame_cnt - 1;
  end
  assign tx_busy = busy_force | (frame_cnt != 0);

  logic [7:0] exp_q [$];
  int n_run = 0, n_fail = 0, n_starts = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: every start pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (rstn && tx_start) begin
      n_starts++;
      if (exp_q.size() == 0) begin
        n_run++;
        n_fail++;
        $display("FAIL unexpected_tx_start: got data %0h expected no pulse", tx_data);
      end else begin
        chk("tx_data_order", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic do_push(input logic [7:0] d, input bit queue_it);
    push_valid = 1'b1;
    push_data  = d;
    if (queue_it) exp_q.push_back(d);
    @(negedge clk);
    push_valid = 1'b0;
  endtask

  task automatic wait_drain(input int max);
    int i = 0;
    while (exp_q.size() != 0 && i < max) begin
      @(negedge clk);
      i++;
    end
    chk("drain_left", exp_q.size(), 0);
    repeat (FRAME + 8) @(negedge clk);
    chk("drain_count", {28'h0, count}, 0);
  endtask

  task automatic wait_start(input int max);
    int i = 0;
    while (!tx_start && i < max) begin
      @(negedge clk);
      i++;
    end
    chk("start_seen", {31'h0, tx_start}, 1);
  endtask

  task automatic wait_hs(input int max);
    int i = 0;
    while (!hs_done && i < max) begin
      @(negedge clk);
      i++;
    end
    chk("hs_done_set", {31'h0, hs_done}, 1);
  endtask

  task automatic apply_reset(input string tag);
    busy_force = 1'b0;
    push_valid = 1'b0;
    hs_req     = 1'b0;
    mode       = 3'd0;
    rstn       = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk({tag, "_push_ready"}, {31'h0, push_ready}, 1);
    chk({tag, "_count"},      {28'h0, count}, 0);
    chk({tag, "_tx_start"},   {31'h0, tx_start}, 0);
    chk({tag, "_tx_data"},    {24'h0, tx_data}, 0);
    chk({tag, "_hs_done"},    {31'h0, hs_done}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, c0;
    logic [AW-1:0] r0, r1;

    // reset state
    apply_reset("rst");

    // handshake in LOAD mode, exactly one pulse even with hs_req held
    mode   = 3'd1;
    hs_req = 1'b1;
    exp_q.push_back(8'hAA);
    s0 = n_starts;
    wait_hs(100);
    chk("hs_one_pulse", n_starts - s0, 1);
    repeat (30) @(negedge clk);
    chk("hs_no_repeat", n_starts - s0, 1);
    hs_req = 1'b0;

    // three bytes back to back; first start in the cycle after edge E+3
    mode = 3'd2;
    c0 = cyc;
    do_push(8'h41, 1);
    do_push(8'h42, 1);
    do_push(8'h43, 1);
    wait_start(10);
    chk("first_latency", cyc, c0 + 4);
    wait_drain(200);

    // fill to capacity with uart_tx busy; 8th push ignored
    busy_force = 1'b1;
    for (int i = 0; i < 7; i++) do_push(8'h10 + 8'(i), 1);
    chk("full_count", {28'h0, count}, 7);
    chk("full_ready", {31'h0, push_ready}, 0);
    push_valid = 1'b1;
    push_data  = 8'h17;
    #1 chk("full_no_we", {31'h0, buf_we}, 0);
    @(negedge clk);
    push_valid = 1'b0;
    chk("full_ignored", {28'h0, count}, 7);
    busy_force = 1'b0;
    wait_drain(400);

    // simultaneous push and read issue at count=1
    busy_force = 1'b1;
    do_push(8'h55, 1);
    chk("sim_pre_count", {28'h0, count}, 1);
    busy_force = 1'b0;
    push_valid = 1'b1;
    push_data  = 8'h56;
    exp_q.push_back(8'h56);
    #1 chk("sim_we", {31'h0, buf_we}, 1);
    r0 = buf_raddr;
    r1 = r0 + 1'b1;
    @(negedge clk);
    push_valid = 1'b0;
    chk("sim_count", {28'h0, count}, 1);
    chk("sim_rptr", {29'h0, buf_raddr}, {29'h0, r1});
    wait_drain(200);

    // mode flips to LOAD with hs_req while ring byte 1 is in flight
    apply_reset("rst2");
    mode       = 3'd2;
    busy_force = 1'b1;
    do_push(8'h61, 1);
    do_push(8'h62, 0);
    busy_force = 1'b0;
    wait_start(20);
    @(negedge clk);
    mode   = 3'd1;
    hs_req = 1'b1;
    exp_q.push_back(8'hAA);
    wait_hs(200);
    chk("held_count", {28'h0, count}, 1);
    repeat (40) @(negedge clk);
    chk("still_held", {28'h0, count}, 1);
    mode   = 3'd2;
    hs_req = 1'b0;
    exp_q.push_back(8'h62);
    wait_drain(200);

    // asynchronous reset while in TX_WAIT
    do_push(8'h71, 1);
    do_push(8'h72, 0);
    wait_start(20);
    repeat (5) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("arst_tx_start",   {31'h0, tx_start}, 0);
    chk("arst_tx_data",    {24'h0, tx_data}, 0);
    chk("arst_count",      {28'h0, count}, 0);
    chk("arst_push_ready", {31'h0, push_ready}, 1);
    chk("arst_hs_done",    {31'h0, hs_done}, 0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (30) @(negedge clk);
    chk("post_arst_count", {28'h0, count}, 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
